// File: rtl/argmax_stream_ctrl_if.sv
// Score stream and result handshake bundle for argmax_stream_ctrl.
// Carries out_max only when SOFTMAX_MAXVAL_EN is defined.
interface argmax_stream_ctrl_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LAYER_SIZE = 10
);
  localparam int IDX_W = $clog2(LAYER_SIZE);

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     out_idx;
`ifdef SOFTMAX_MAXVAL_EN
  logic [WORD_SIZE-1:0] out_max;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_max
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_max
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx
  );
`endif
endinterface

// File: rtl/argmax_stream_ctrl.sv
// Streaming argmax over LAYER_SIZE signed scores, one comparator reused.
// SOFTMAX_MAXVAL_EN adds out_max (winning score) to the result.
module argmax_stream_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int LAYER_SIZE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  argmax_stream_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(LAYER_SIZE);
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(LAYER_SIZE-1);
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W:0]              count_q;
  logic signed [WORD_SIZE-1:0] max_q;
  logic [IDX_W-1:0]            idx_q;
  logic [IDX_W-1:0]            res_idx_q;
`ifdef SOFTMAX_MAXVAL_EN
  logic signed [WORD_SIZE-1:0] res_max_q;
`endif

  logic                        beat;
  logic                        take;
  logic                        last;
  logic signed [WORD_SIZE-1:0] win_max;
  logic [IDX_W-1:0]            win_idx;

  // abort wins over a beat presented in the same cycle
  assign beat = (state_q == ACCUM) && bus.in_valid && !abort;
  assign take = (count_q == '0)
             || ($signed(bus.in_data) > max_q);
  assign win_max = take ? $signed(bus.in_data) : max_q;
  assign win_idx = take ? count_q[IDX_W-1:0] : idx_q;
  assign last    = (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (beat && last) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // result regs load on the last beat so they hold through IDLE/ACCUM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      res_idx_q <= '0;
`ifdef SOFTMAX_MAXVAL_EN
      res_max_q <= '0;
`endif
    end else if (abort) begin
      count_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        count_q <= '0;
      end
      if (beat) begin
        max_q   <= win_max;
        idx_q   <= win_idx;
        count_q <= count_q + ONE;
        if (last) begin
          res_idx_q <= win_idx;
`ifdef SOFTMAX_MAXVAL_EN
          res_max_q <= win_max;
`endif
        end
      end
    end
  end

  assign bus.out_idx = res_idx_q;
`ifdef SOFTMAX_MAXVAL_EN
  assign bus.out_max = res_max_q;
`endif

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// Randomized bench for argmax_stream_ctrl against a queue-based model.
// Define SOFTMAX_MAXVAL_EN to also check out_max.
module tb_argmax_stream_ctrl;
  localparam int WS = 16;
  localparam int LS = 10;
  localparam int IW = $clog2(LS);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;

  argmax_stream_ctrl_if #(.WORD_SIZE(WS), .LAYER_SIZE(LS)) bus ();

  argmax_stream_ctrl #(.WORD_SIZE(WS), .LAYER_SIZE(LS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int c0     = 0;
  int dut_res = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: phase 0 idle, 1 collecting, 2 holding result
  int                     phase = 0;
  logic signed [WS-1:0]   q[$];
  logic [IW-1:0]          m_idx = '0;
  logic signed [WS-1:0]   m_max = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      q.delete();
      m_idx = '0;
      m_max = '0;
    end else if (abort) begin
      phase = 0;
      q.delete();
    end else begin
      case (phase)
        0: if (start) begin
          phase = 1;
          q.delete();
        end
        1: if (bus.in_valid) begin
          q.push_back(bus.in_data);
          if (q.size() == LS) begin
            int best;
            best = 0;
            for (int k = 1; k < LS; k++)
              if (q[k] > q[best]) best = k;
            m_idx = IW'(best);
            m_max = q[best];
            phase = 2;
          end
        end
        2: if (bus.out_ready) phase = 0;
        default: phase = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.out_valid && bus.out_ready) dut_res++;
  end

  always @(negedge clk) begin
    check("in_ready", 32'(bus.in_ready), 32'(phase == 1));
    check("out_valid", 32'(bus.out_valid), 32'(phase == 2));
    check("busy", 32'(busy), 32'(phase != 0));
    check("out_idx", 32'(bus.out_idx), 32'(m_idx));
`ifdef SOFTMAX_MAXVAL_EN
    check("out_max", 32'(bus.out_max), 32'(m_max));
`endif
  end

  logic signed [WS-1:0] scores[LS];

  function automatic int ref_argmax();
    int b;
    b = 0;
    for (int k = 1; k < LS; k++)
      if (scores[k] > scores[b]) b = k;
    return b;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap_pct);
    int  i;
    int  to;
    logic v;
    logic acc;
    i  = 0;
    to = 0;
    while (i < n && to < 1000) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      bus.in_valid = v;
      bus.in_data  = scores[i];
      acc = v && bus.in_ready;
      @(negedge clk);
      if (acc) i++;
      to++;
    end
    bus.in_valid = 1'b0;
    if (to >= 1000) check("feed_timeout", 32'(i), 32'(n));
  endtask

  task automatic run_frame(input int gap, input int hold,
                           output int lat,
                           output logic [IW-1:0] idx,
                           output logic [WS-1:0] mx);
    int to;
    do_start();
    feed(LS, gap);
    to = 0;
    while (!bus.out_valid && to < 200) begin
      @(negedge clk);
      to++;
    end
    if (to >= 200) check("result_timeout", 32'(bus.out_valid), 32'd1);
    lat = cyc - c0;
    idx = bus.out_idx;
`ifdef SOFTMAX_MAXVAL_EN
    mx = bus.out_max;
`else
    mx = '0;
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_idx", 32'(bus.out_idx), 32'(idx));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("released", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int            lat;
  logic [IW-1:0] idx;
  logic [WS-1:0] mx;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);

    // tie between idx 2 and 4 must keep 2
    scores = '{16'sd3, -16'sd1, 16'sd7, 16'sd2, 16'sd7,
               16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    run_frame(0, 0, lat, idx, mx);
    check("s2_idx", 32'(idx), 32'd2);
    check("s2_latency", 32'(lat), 32'd11);
`ifdef SOFTMAX_MAXVAL_EN
    check("s2_max", 32'(mx), 32'd7);
`endif

    // async reset in the middle of accumulation
    do_start();
    feed(3, 0);
    #2 rst_n = 1'b0;
    #1;
    check("amid_in_ready", 32'(bus.in_ready), 32'd0);
    check("amid_out_valid", 32'(bus.out_valid), 32'd0);
    check("amid_busy", 32'(busy), 32'd0);
    check("amid_out_idx", 32'(bus.out_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < LS; k++) scores[k] = 16'sh8000;
    run_frame(0, 0, lat, idx, mx);
    check("s3_all_min_idx", 32'(idx), 32'd0);
    scores[9] = 16'sh7FFF;
    run_frame(0, 1, lat, idx, mx);
    check("s3_last_max_idx", 32'(idx), 32'd9);

    // random frames with gaps, ties and delayed out_ready
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < LS; k++) begin
        if (f % 2 == 0) scores[k] = WS'(int'($urandom_range(0, 6)) - 3);
        else scores[k] = WS'($urandom);
      end
      run_frame(30, (f == 0) ? 5 : int'($urandom_range(0, 5)), lat, idx, mx);
      check("rand_idx", 32'(idx), 32'(ref_argmax()));
      check("rand_min_latency", 32'(lat >= 11), 32'd1);
    end

    // aborted frame must not produce a result
    for (int k = 0; k < LS; k++) scores[k] = WS'(k);
    do_start();
    feed(4, 0);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh7FFF;
    @(negedge clk);
    abort = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < LS; k++) scores[k] = -WS'(k);
    scores[6] = 16'sd100;
    run_frame(20, 2, lat, idx, mx);
    check("s5_idx", 32'(idx), 32'd6);
`ifdef SOFTMAX_MAXVAL_EN
    check("s5_max", 32'(mx), 32'd100);
`endif

    repeat (3) @(negedge clk);
    check("result_count", 32'(dut_res), 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
